// File: rtl/rsa_keygen_seq_if.sv
// Handshake bundle for rsa_keygen_seq: request channel (P, Q, E) and
// response channel (N, D, err), each with its own valid/ready pair.
interface rsa_keygen_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_p;
  logic [WIDTH-1:0]   in_q;
  logic [2*WIDTH-1:0] in_e;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_n;
  logic [2*WIDTH-1:0] out_d;
  logic               out_err;

  // Requester side: drives the request and accepts the response.
  modport master (
    output in_valid, in_p, in_q, in_e, out_ready,
    input  in_ready, out_valid, out_n, out_d, out_err
  );

  // Key generator side.
  modport slave (
    input  in_valid, in_p, in_q, in_e, out_ready,
    output in_ready, out_valid, out_n, out_d, out_err
  );
endinterface

// File: rtl/rsa_keygen_seq.sv
// Sequential RSA key generator: N = P*Q and D = E^-1 mod (P-1)(Q-1),
// computed with one extended-Euclid division step per clock.
// Optional feature macro: RSA_KEYGEN_VERIFY_EN adds a VERIFY state that
// re-checks (E*D) mod phi == 1 before presenting the result.
module rsa_keygen_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  rsa_keygen_seq_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int TW = W2 + 1;  // signed width of the Bezout coefficients

  typedef enum logic [2:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_VERIFY,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [W2-1:0]         r0_q, r0_d, r1_q, r1_d;
  logic signed [TW-1:0]  t0_q, t0_d, t1_q, t1_d;
  logic [W2-1:0]         e_q, e_d, phi_q, phi_d, n_q, n_d;
  logic                  bad_q, bad_d;  // P or Q below 2
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [W2-1:0]         out_n_q, out_n_d, out_d_q, out_d_d;
  logic                  out_err_q, out_err_d;

  logic [W2-1:0]         quo, rem, n_full;
  logic signed [TW-1:0]  prod, t_fix;
  logic                  err_fix;

`ifdef RSA_KEYGEN_VERIFY_EN
  localparam int W4 = 2 * W2;
  logic [W4-1:0]         ed_prod, ed_mod;
`endif

  // Next-state and next-output logic for the whole FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    e_d         = e_q;
    phi_d       = phi_q;
    n_d         = n_q;
    bad_d       = bad_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_n_d     = out_n_q;
    out_d_d     = out_d_q;
    out_err_d   = out_err_q;
    quo         = '0;
    rem         = '0;
    n_full      = '0;
    prod        = '0;
    t_fix       = '0;
    err_fix     = 1'b0;
`ifdef RSA_KEYGEN_VERIFY_EN
    ed_prod     = '0;
    ed_mod      = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          n_full     = W2'(bus.in_p) * W2'(bus.in_q);
          n_d        = n_full;
          phi_d      = n_full - W2'(bus.in_p) - W2'(bus.in_q) + W2'(1);
          r0_d       = n_full - W2'(bus.in_p) - W2'(bus.in_q) + W2'(1);
          r1_d       = bus.in_e;
          t0_d       = '0;
          t1_d       = TW'(1);
          e_d        = bus.in_e;
          bad_d      = (bus.in_p < WIDTH'(2)) || (bus.in_q < WIDTH'(2));
          in_ready_d = 1'b0;
          state_d    = S_ITER;
        end
      end

      S_ITER: begin
        // Divide only while the divisor is non-zero.
        if (r1_q != '0) begin
          quo  = r0_q / r1_q;
          rem  = r0_q % r1_q;
          prod = $signed({1'b0, quo}) * t1_q;
          r0_d = r1_q;
          r1_d = rem;
          t0_d = t1_q;
          t1_d = t0_q - prod;
        end else begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        err_fix   = (r0_q != W2'(1)) || (e_q == '0) || (e_q >= phi_q) || bad_q;
        t_fix     = t0_q[TW-1] ? (t0_q + $signed({1'b0, phi_q})) : t0_q;
        out_n_d   = n_q;
        out_err_d = err_fix;
        out_d_d   = err_fix ? '0 : t_fix[W2-1:0];
`ifdef RSA_KEYGEN_VERIFY_EN
        state_d   = S_VERIFY;
`else
        out_valid_d = 1'b1;
        state_d     = S_DONE;
`endif
      end

`ifdef RSA_KEYGEN_VERIFY_EN
      S_VERIFY: begin
        ed_prod = W4'(e_q) * W4'(out_d_q);
        if (phi_q != '0) ed_mod = ed_prod % W4'(phi_q);
        if ((phi_q == '0) || (ed_mod != W4'(1))) begin
          out_err_d = 1'b1;
          out_d_d   = '0;
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
`endif

      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and reopens the input.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      r0_q        <= '0;
      r1_q        <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      e_q         <= '0;
      phi_q       <= '0;
      n_q         <= '0;
      bad_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
      out_d_q     <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      e_q         <= e_d;
      phi_q       <= phi_d;
      n_q         <= n_d;
      bad_q       <= bad_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
      out_d_q     <= out_d_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_n     = out_n_q;
  assign bus.out_d     = out_d_q;
  assign bus.out_err   = out_err_q;
endmodule
